// File: rtl/tm1638_pkg.sv
// rtl/tm1638_pkg.sv - shared constants and FSM state type for the TM1638 controller
package tm1638_pkg;

    localparam logic [7:0] CMD_READ_KEYS = 8'h42;
    localparam int         NUM_KEY_BYTES = 4;
    localparam int         KEY_BITS      = 8 * NUM_KEY_BYTES;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        CMD,
        WAIT,
        READ,
        DONE
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous input
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tm1638_key_reader.sv
// rtl/tm1638_key_reader.sv - issues the TM1638 read-key command and returns the 32-bit key bitmap
module tm1638_key_reader
    import tm1638_pkg::*;
#(
    parameter int CLK_DIV     = 49,
    parameter int WAIT_CYCLES = 100
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_Start,
    output logic        o_Busy,
    output logic        o_Keys_Valid,
    output logic [31:0] o_Keys,
    output logic        o_SPI_Stb,
    output logic        o_SPI_Clk,
    output logic        o_SPI_Dio_Out,
    output logic        o_SPI_Dio_Oe,
    input  logic        i_SPI_Dio
);

    // One down-counter times both the SPI half periods and the Twait gap.
    localparam int CNT_MAX = (CLK_DIV > WAIT_CYCLES - 1) ? CLK_DIV : WAIT_CYCLES - 1;
    localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam int BW      = $clog2(KEY_BITS);

    localparam logic [CW-1:0] HALF_RELOAD = CW'(CLK_DIV);
    localparam logic [CW-1:0] WAIT_RELOAD = CW'(WAIT_CYCLES - 1);
    localparam logic [BW-1:0] LAST_CMD    = BW'(7);
    localparam logic [BW-1:0] LAST_READ   = BW'(KEY_BITS - 1);

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [BW-1:0]         bit_cnt, bit_n;
    logic                  phase, phase_n;
    logic [KEY_BITS-1:0]   shreg, shreg_n;
    logic [KEY_BITS-1:0]   keys, keys_n;
    logic                  dio_s;
    logic                  cnt_zero;

    sync_2ff u_dio_sync (
        .clk   (i_Clk),
        .rst_n (i_Rst),
        .d     (i_SPI_Dio),
        .q     (dio_s)
    );

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            phase   <= 1'b0;
            shreg   <= '0;
            keys    <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_cnt <= bit_n;
            phase   <= phase_n;
            shreg   <= shreg_n;
            keys    <= keys_n;
        end
    end

    assign cnt_zero = (cnt == '0);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_cnt;
        phase_n = phase;
        shreg_n = shreg;
        keys_n  = keys;
        case (state)
            IDLE: begin
                if (i_Start) begin
                    state_n = SETUP;
                    cnt_n   = HALF_RELOAD;
                end
            end
            SETUP: begin
                if (!cnt_zero) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    state_n = CMD;
                    cnt_n   = HALF_RELOAD;
                    phase_n = 1'b0;
                    bit_n   = '0;
                end
            end
            CMD: begin
                if (!cnt_zero) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    cnt_n = HALF_RELOAD;
                    if (!phase) begin
                        phase_n = 1'b1;
                    end else begin
                        phase_n = 1'b0;
                        if (bit_cnt == LAST_CMD) begin
                            state_n = WAIT;
                            cnt_n   = WAIT_RELOAD;
                            bit_n   = '0;
                        end else begin
                            bit_n = bit_cnt + 1'b1;
                        end
                    end
                end
            end
            WAIT: begin
                if (!cnt_zero) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    state_n = READ;
                    cnt_n   = HALF_RELOAD;
                    phase_n = 1'b0;
                end
            end
            READ: begin
                if (!cnt_zero) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    cnt_n = HALF_RELOAD;
                    if (!phase) begin
                        phase_n = 1'b1;
                    end else begin
                        // Sample at the end of the high half; first bit ends up in bit 0.
                        phase_n = 1'b0;
                        shreg_n = {dio_s, shreg[KEY_BITS-1:1]};
                        if (bit_cnt == LAST_READ) begin
                            state_n = DONE;
                            keys_n  = shreg_n;
                        end else begin
                            bit_n = bit_cnt + 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        o_SPI_Dio_Out = 1'b1;
        o_SPI_Dio_Oe  = 1'b0;
        o_SPI_Clk     = 1'b1;
        case (state)
            SETUP: begin
                o_SPI_Dio_Out = CMD_READ_KEYS[0];
                o_SPI_Dio_Oe  = 1'b1;
            end
            CMD: begin
                o_SPI_Dio_Out = CMD_READ_KEYS[bit_cnt[2:0]];
                o_SPI_Dio_Oe  = 1'b1;
                o_SPI_Clk     = phase;
            end
            READ: begin
                o_SPI_Clk = phase;
            end
            default: begin
                o_SPI_Dio_Out = 1'b1;
            end
        endcase
    end

    assign o_Busy       = (state != IDLE) && (state != DONE);
    assign o_SPI_Stb    = !o_Busy;
    assign o_Keys_Valid = (state == DONE);
    assign o_Keys       = keys;

endmodule

// File: tb/tb_tm1638_key_reader.sv
// tb/tb_tm1638_key_reader.sv - directed bench with a TM1638 DIO model for tm1638_key_reader
module tb_tm1638_key_reader;

    logic        i_Clk;
    logic        i_Rst;
    logic        i_Start;
    logic        o_Busy;
    logic        o_Keys_Valid;
    logic [31:0] o_Keys;
    logic        o_SPI_Stb;
    logic        o_SPI_Clk;
    logic        o_SPI_Dio_Out;
    logic        o_SPI_Dio_Oe;
    logic        i_SPI_Dio = 1'b1;

    tm1638_key_reader #(.CLK_DIV(2), .WAIT_CYCLES(4)) dut (
        .i_Clk         (i_Clk),
        .i_Rst         (i_Rst),
        .i_Start       (i_Start),
        .o_Busy        (o_Busy),
        .o_Keys_Valid  (o_Keys_Valid),
        .o_Keys        (o_Keys),
        .o_SPI_Stb     (o_SPI_Stb),
        .o_SPI_Clk     (o_SPI_Clk),
        .o_SPI_Dio_Out (o_SPI_Dio_Out),
        .o_SPI_Dio_Oe  (o_SPI_Dio_Oe),
        .i_SPI_Dio     (i_SPI_Dio)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    int errors = 0;
    int checks = 0;

    // TM1638 model: latches command bits on rising CLK, drives key bits on falling CLK.
    logic [31:0] tx_word = 32'h0;
    logic [7:0]  cmd_cap = 8'h0;
    int          rise_cnt = 0;
    logic        m_stb = 1'b1;
    logic        m_clk = 1'b1;

    always @(o_SPI_Stb, o_SPI_Clk) begin
        if (m_stb && !o_SPI_Stb) begin
            rise_cnt = 0;
            cmd_cap  = 8'h0;
        end else if (!o_SPI_Stb && !m_clk && o_SPI_Clk) begin
            if (rise_cnt < 8) cmd_cap[rise_cnt] = o_SPI_Dio_Out;
            rise_cnt++;
        end else if (!o_SPI_Stb && m_clk && !o_SPI_Clk && rise_cnt >= 8 && rise_cnt < 40) begin
            i_SPI_Dio = tx_word[rise_cnt-8];
        end
        m_stb = o_SPI_Stb;
        m_clk = o_SPI_Clk;
    end

    // Cycle monitor on the falling system-clock edge; low_cnt is 1-based within a transaction.
    int   cyc = 0;
    int   low_cnt = 0;
    int   last_low_len = 0;
    int   n_fall = 0;
    int   n_valid = 0;
    int   oe_bad = 0;
    int   oe_cmd_bad = 0;
    int   clk_idle_bad = 0;
    int   fall_log [64];
    int   done_log [64];
    logic prev_stb = 1'b1;

    always @(negedge i_Clk) begin
        cyc++;
        if (!o_SPI_Stb) begin
            if (prev_stb) begin
                if (n_fall < 64) fall_log[n_fall] = cyc;
                n_fall++;
                low_cnt = 1;
            end else begin
                low_cnt++;
            end
            if (low_cnt > 51 && o_SPI_Dio_Oe) oe_bad++;
            if (low_cnt <= 51 && !o_SPI_Dio_Oe) oe_cmd_bad++;
        end else begin
            if (!prev_stb) last_low_len = low_cnt;
            if (!o_SPI_Clk) clk_idle_bad++;
        end
        if (o_Keys_Valid) begin
            if (n_valid < 64) done_log[n_valid] = cyc;
            n_valid++;
        end
        prev_stb = o_SPI_Stb;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #2;
    endtask

    task automatic pulse_start();
        i_Start = 1'b1;
        tick();
        i_Start = 1'b0;
    endtask

    task automatic wait_valid(input int target, input string tag);
        int t = 0;
        while (n_valid < target && t < 2000) begin
            tick();
            t++;
        end
        check(tag, 32'(n_valid >= target), 32'd1);
    endtask

    int v0, f0, e0, t;

    initial begin
        i_Rst   = 1'b0;
        i_Start = 1'b0;
        #1;
        check("rst_stb",   32'(o_SPI_Stb), 32'd1);
        check("rst_clk",   32'(o_SPI_Clk), 32'd1);
        check("rst_dio",   32'(o_SPI_Dio_Out), 32'd1);
        check("rst_oe",    32'(o_SPI_Dio_Oe), 32'd0);
        check("rst_busy",  32'(o_Busy), 32'd0);
        check("rst_valid", 32'(o_Keys_Valid), 32'd0);
        check("rst_keys",  o_Keys, 32'h0);
        repeat (3) tick();
        i_Rst = 1'b1;
        repeat (3) tick();

        // 1: bytes 01,80,00,A5
        tx_word = {8'hA5, 8'h00, 8'h80, 8'h01};
        v0 = n_valid;
        pulse_start();
        check("t1_busy_cycle1", 32'(o_Busy), 32'd1);
        check("t1_stb_cycle1",  32'(o_SPI_Stb), 32'd0);
        wait_valid(v0 + 1, "t1_timeout");
        check("t1_keys",      o_Keys, 32'hA5008001);
        check("t1_cmd_byte",  32'(cmd_cap), 32'h42);
        check("t1_clk_edges", 32'(rise_cnt), 32'd40);
        check("t1_stb_len",   32'(last_low_len), 32'd247);
        check("t1_done_busy", 32'(o_Busy), 32'd0);
        tick();
        check("t1_valid_width", 32'(o_Keys_Valid), 32'd0);
        check("t1_valid_count", 32'(n_valid - v0), 32'd1);
        repeat (5) tick();

        // 2: all ones, DIO released through WAIT and READ
        tx_word = 32'hFFFFFFFF;
        v0 = n_valid;
        e0 = oe_bad;
        t  = oe_cmd_bad;
        pulse_start();
        wait_valid(v0 + 1, "t2_timeout");
        check("t2_keys",   o_Keys, 32'hFFFFFFFF);
        check("t2_oe_off", 32'(oe_bad - e0), 32'd0);
        check("t2_oe_on",  32'(oe_cmd_bad - t), 32'd0);
        repeat (5) tick();

        // 3: start held high for 300 cycles
        tx_word = 32'h0F0F0F0F;
        v0 = n_valid;
        f0 = n_fall;
        i_Start = 1'b1;
        repeat (300) tick();
        i_Start = 1'b0;
        wait_valid(v0 + 2, "t3_timeout");
        repeat (30) tick();
        check("t3_two_txn",   32'(n_fall - f0), 32'd2);
        check("t3_two_valid", 32'(n_valid - v0), 32'd2);
        check("t3_b2b_gap",   32'(fall_log[f0+1] - done_log[v0]), 32'd2);
        check("t3_keys",      o_Keys, 32'h0F0F0F0F);

        v0 = n_valid;
        f0 = n_fall;
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            repeat (30) tick();
            pulse_start();
        end
        wait_valid(v0 + 1, "t3b_timeout");
        repeat (30) tick();
        check("t3b_one_txn",   32'(n_fall - f0), 32'd1);
        check("t3b_one_valid", 32'(n_valid - v0), 32'd1);

        // 4: reset mid-READ
        tx_word = 32'h12345678;
        v0 = n_valid;
        f0 = n_fall;
        pulse_start();
        t = 0;
        while (!(n_fall > f0 && low_cnt >= 120) && t < 1000) begin
            tick();
            t++;
        end
        check("t4_reached_read", 32'(low_cnt), 32'd120);
        check("t4_busy_before",  32'(o_Busy), 32'd1);
        i_Rst = 1'b0;
        #1;
        check("t4_stb",  32'(o_SPI_Stb), 32'd1);
        check("t4_clk",  32'(o_SPI_Clk), 32'd1);
        check("t4_oe",   32'(o_SPI_Dio_Oe), 32'd0);
        check("t4_keys", o_Keys, 32'h0);
        check("t4_busy", 32'(o_Busy), 32'd0);
        repeat (3) tick();
        i_Rst = 1'b1;
        repeat (300) tick();
        check("t4_no_valid",   32'(n_valid - v0), 32'd0);
        check("t4_keys_clear", o_Keys, 32'h0);
        tx_word = {8'h78, 8'h56, 8'h34, 8'h12};
        pulse_start();
        wait_valid(v0 + 1, "t4b_timeout");
        check("t4b_keys",    o_Keys, 32'h78563412);
        check("t4b_stb_len", 32'(last_low_len), 32'd247);
        check("t4b_cmd",     32'(cmd_cap), 32'h42);
        repeat (5) tick();

        // 5: alternating bytes, hold until next DONE
        tx_word = {8'hAA, 8'h55, 8'hAA, 8'h55};
        v0 = n_valid;
        pulse_start();
        wait_valid(v0 + 1, "t5_timeout");
        check("t5_keys", o_Keys, 32'hAA55AA55);
        repeat (50) tick();
        check("t5_hold_idle", o_Keys, 32'hAA55AA55);
        check("t5_clk_idle",  32'(o_SPI_Clk), 32'd1);
        tx_word = 32'h0;
        f0 = n_fall;
        pulse_start();
        t = 0;
        while (!(n_fall > f0 && low_cnt >= 200) && t < 1000) begin
            tick();
            t++;
        end
        check("t5_hold_busy", o_Keys, 32'hAA55AA55);
        wait_valid(v0 + 2, "t5b_timeout");
        check("t5b_keys", o_Keys, 32'h0);
        repeat (10) tick();
        check("clk_idle_high", 32'(clk_idle_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
